// File: rtl/sensor_sampler_pkg.sv
// Shared constants, FSM encoding and sample-word types for the gyro/accelerometer sampler.
package sensor_sampler_pkg;

  localparam logic SEL_GYRO = 1'b0;
  localparam logic SEL_ACCL = 1'b1;

  localparam logic [7:0] GYRO_CMD_DEF   = 8'hE8;
  localparam logic [7:0] ACCL_CMD_DEF   = 8'hF2;
  localparam logic [2:0] XFER_BYTES_DEF = 3'd7;
  localparam logic [2:0] DATA_BYTES     = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    G_REQ     = 3'd1,
    G_COLLECT = 3'd2,
    A_REQ     = 3'd3,
    A_COLLECT = 3'd4,
    PUBLISH   = 3'd5
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } axis3_t;

  // Sensor words arrive low byte first.
  function automatic logic [15:0] le_word(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/sensor_sampler_if.sv
// Command/response link between the sampler (master) and the SPI byte engine (slave).
interface sensor_sampler_if;

  logic       write_ready;
  logic       read_ready;
  logic [7:0] read_data;
  logic       write_start;
  logic [7:0] write_data;
  logic [2:0] write_count_bytes;
  logic       sensor_select;

  modport master (
    input  write_ready, read_ready, read_data,
    output write_start, write_data, write_count_bytes, sensor_select
  );

  modport slave (
    output write_ready, read_ready, read_data,
    input  write_start, write_data, write_count_bytes, sensor_select
  );

endinterface

// File: rtl/sensor_sampler_sample_assembler.sv
// Six-byte staging register with slot counter; status and word view show the
// contents including any byte accepted this cycle.
module sample_assembler
  import sensor_sampler_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       wr_en_i,
  input  logic [7:0] byte_i,
  output logic [2:0] count_o,
  output logic       overflow_o,
  output axis3_t     words_o
);

  logic [7:0] bytes_q [0:5];
  logic [7:0] bytes_d [0:5];
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  // Slot fill: a byte beyond the sixth is dropped and marks the frame bad.
  always_comb begin
    bytes_d = bytes_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      for (int i = 0; i < 6; i++) begin
        bytes_d[i] = 8'h00;
      end
      count_d = 3'd0;
      ovf_d   = 1'b0;
    end else if (wr_en_i) begin
      if (count_q >= DATA_BYTES) begin
        ovf_d = 1'b1;
      end else begin
        bytes_d[count_q] = byte_i;
        count_d          = count_q + 3'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 6; i++) begin
        bytes_q[i] <= 8'h00;
      end
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        bytes_q[i] <= bytes_d[i];
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_d;
  assign overflow_o = ovf_d;
  assign words_o.x  = le_word(bytes_d[0], bytes_d[1]);
  assign words_o.y  = le_word(bytes_d[2], bytes_d[3]);
  assign words_o.z  = le_word(bytes_d[4], bytes_d[5]);

endmodule

// File: rtl/sensor_sampler.sv
// Gyro then accelerometer burst-read sequencer; publishes all six axes atomically
// only when both six-byte frames arrive intact.
module sensor_sampler
  import sensor_sampler_pkg::*;
#(
  parameter logic [7:0] GYRO_CMD   = GYRO_CMD_DEF,
  parameter logic [7:0] ACCL_CMD   = ACCL_CMD_DEF,
  parameter logic [2:0] XFER_BYTES = XFER_BYTES_DEF
)(
  input  logic               div_clk,
  input  logic               reset,
  input  logic               sample_tick,
  sensor_sampler_if.master   spi,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic signed [15:0] accl_x,
  output logic signed [15:0] accl_y,
  output logic signed [15:0] accl_z,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun,
  output logic               frame_error
);

  state_e     state_q, state_d;
  logic       arm_q;
  logic       sel_q;
  logic       sample_valid_q;
  logic       frame_error_q;
  logic       overrun_q;
  axis3_t     gyro_stage_q;
  axis3_t     gyro_out_q;
  axis3_t     accl_out_q;

  logic       write_start_s;
  logic [7:0] write_data_s;
  logic       clr_s;
  logic       collect_s;
  logic       exit_s;
  logic       frame_ok_s;
  logic [2:0] asm_count_s;
  logic       asm_ovf_s;
  axis3_t     asm_words_s;

  sample_assembler u_assembler (
    .clk_i      (div_clk),
    .reset_i    (reset),
    .clr_i      (clr_s),
    .wr_en_i    (collect_s & spi.read_ready),
    .byte_i     (spi.read_data),
    .count_o    (asm_count_s),
    .overflow_o (asm_ovf_s),
    .words_o    (asm_words_s)
  );

  assign frame_ok_s = (asm_count_s == DATA_BYTES) && !asm_ovf_s;

  // arm_q masks the first collect cycle, when the SPI stage may not yet have dropped write_ready.
  always_comb begin
    state_d       = state_q;
    write_start_s = 1'b0;
    write_data_s  = 8'h00;
    clr_s         = 1'b0;
    collect_s     = 1'b0;
    exit_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = G_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      G_REQ, A_REQ: begin
        clr_s = 1'b1;
        if (spi.write_ready) begin
          write_start_s = 1'b1;
          write_data_s  = (state_q == A_REQ) ? ACCL_CMD : GYRO_CMD;
          state_d       = (state_q == A_REQ) ? A_COLLECT : G_COLLECT;
        end else begin
          state_d = state_q;
        end
      end
      G_COLLECT, A_COLLECT: begin
        collect_s = 1'b1;
        if (arm_q && spi.write_ready) begin
          exit_s = 1'b1;
          if (!frame_ok_s) begin
            state_d = IDLE;
          end else if (state_q == G_COLLECT) begin
            state_d = A_REQ;
          end else begin
            state_d = PUBLISH;
          end
        end else begin
          state_d = state_q;
        end
      end
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, handshake select and status pulses.
  always_ff @(posedge div_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      arm_q          <= 1'b0;
      sel_q          <= SEL_GYRO;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      arm_q          <= collect_s;
      sample_valid_q <= exit_s && frame_ok_s && (state_q == A_COLLECT);
      frame_error_q  <= exit_s && !frame_ok_s;
      overrun_q      <= overrun_q | (sample_tick && (state_q != IDLE));
      if ((state_d == G_REQ) && (state_q != G_REQ)) begin
        sel_q <= SEL_GYRO;
      end else if ((state_d == A_REQ) && (state_q != A_REQ)) begin
        sel_q <= SEL_ACCL;
      end else begin
        sel_q <= sel_q;
      end
    end
  end

  // Gyro words wait in a private stage so both sensors reach the outputs in the same cycle.
  always_ff @(posedge div_clk) begin
    if (reset) begin
      gyro_stage_q <= '0;
      gyro_out_q   <= '0;
      accl_out_q   <= '0;
    end else begin
      if (exit_s && frame_ok_s && (state_q == G_COLLECT)) begin
        gyro_stage_q <= asm_words_s;
      end else begin
        gyro_stage_q <= gyro_stage_q;
      end
      if (exit_s && frame_ok_s && (state_q == A_COLLECT)) begin
        gyro_out_q <= gyro_stage_q;
        accl_out_q <= asm_words_s;
      end else begin
        gyro_out_q <= gyro_out_q;
        accl_out_q <= accl_out_q;
      end
    end
  end

  assign spi.write_start       = write_start_s;
  assign spi.write_data        = write_data_s;
  assign spi.write_count_bytes = XFER_BYTES;
  assign spi.sensor_select     = sel_q;

  assign gyro_x       = gyro_out_q.x;
  assign gyro_y       = gyro_out_q.y;
  assign gyro_z       = gyro_out_q.z;
  assign accl_x       = accl_out_q.x;
  assign accl_y       = accl_out_q.y;
  assign accl_z       = accl_out_q.z;
  assign sample_valid = sample_valid_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_sampler.sv
// Randomised self-checking bench: an SPI responder feeds byte frames and a
// transaction-level model predicts the published words and status flags.
module tb_sensor_sampler;

  logic               div_clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic signed [15:0] gyro_x, gyro_y, gyro_z, accl_x, accl_y, accl_z;
  logic               sample_valid, busy, overrun, frame_error;

  sensor_sampler_if spi_if();

  sensor_sampler dut (
    .div_clk      (div_clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .spi          (spi_if),
    .gyro_x       (gyro_x),
    .gyro_y       (gyro_y),
    .gyro_z       (gyro_z),
    .accl_x       (accl_x),
    .accl_y       (accl_y),
    .accl_z       (accl_z),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .frame_error  (frame_error)
  );

  always #5 div_clk = ~div_clk;

  int n_vec = 0;
  int n_err = 0;
  int ws_count = 0;
  int sv_count = 0;
  int proto_err = 0;
  logic ws_prev = 1'b0;

  logic [7:0]  g_bytes [8];
  logic [7:0]  a_bytes [8];
  logic [15:0] exp_w [6];
  logic        exp_ovr;

  // Mid-cycle observation of the handshake rules and event counts.
  always @(negedge div_clk) begin
    ws_count  <= ws_count + (spi_if.write_start ? 1 : 0);
    sv_count  <= sv_count + (sample_valid ? 1 : 0);
    if ((spi_if.write_start && !spi_if.write_ready) || (spi_if.write_start && ws_prev)) begin
      proto_err <= proto_err + 1;
    end
    ws_prev <= spi_if.write_start;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge div_clk);
    #2;
  endtask

  function automatic logic [15:0] le16(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'(hi) * 256 + int'(lo);
    return 16'(v);
  endfunction

  task automatic check_words(input string tag);
    logic [15:0] got [6];
    got = '{gyro_x, gyro_y, gyro_z, accl_x, accl_y, accl_z};
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp_w[i]));
    end
  endtask

  // One SPI transaction as seen from the byte engine.
  task automatic xfer(input bit accl, input int nb, input bit xtick, input bit rstm,
                      output bit seen, output bit aborted);
    seen    = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (spi_if.write_start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq("ws_seen", 32'(seen), 32'(1));
    if (!seen) return;
    check_eq("cmd_byte", 32'(spi_if.write_data), accl ? 32'h0000_00F2 : 32'h0000_00E8);
    check_eq("sel_at_start", 32'(spi_if.sensor_select), 32'(accl));
    check_eq("count_bytes", 32'(spi_if.write_count_bytes), 32'(7));
    step();
    spi_if.write_ready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if (rstm && i == 3) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        spi_if.write_ready = 1'b1;
        aborted = 1'b1;
        return;
      end
      spi_if.read_ready = 1'b1;
      spi_if.read_data  = accl ? a_bytes[i] : g_bytes[i];
      if (xtick && i == 2) begin
        sample_tick = 1'b1;
        exp_ovr     = 1'b1;
      end
      step();
      spi_if.read_ready = 1'b0;
      sample_tick       = 1'b0;
    end
    check_eq("sel_held", 32'(spi_if.sensor_select), 32'(accl));
    repeat ($urandom_range(0, 1)) step();
    spi_if.write_ready = 1'b1;
    step();
  endtask

  task automatic do_sample(input int gn, input int an, input bit xtick, input int hold, input bit rstm);
    int ws0, sv0;
    bit seen, aborted;
    ws0 = ws_count;
    sv0 = sv_count;
    if (hold > 0) spi_if.write_ready = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_eq("busy_after_tick", 32'(busy), 32'(1));
    if (hold > 0) begin
      repeat (hold) step();
      check_eq("ws_while_not_ready", 32'(ws_count - ws0), 32'(0));
      spi_if.write_ready = 1'b1;
      #1;
    end
    xfer(1'b0, gn, 1'b0, 1'b0, seen, aborted);
    if (!seen) return;
    if (gn != 6) begin
      check_eq("g_frame_error", 32'(frame_error), 32'(1));
      check_eq("g_bad_busy", 32'(busy), 32'(0));
      check_eq("g_bad_valid", 32'(sample_valid), 32'(0));
      check_words("g_bad_hold");
      step();
      check_eq("g_fe_pulse", 32'(frame_error), 32'(0));
      check_eq("g_bad_ws", 32'(ws_count - ws0), 32'(1));
      check_eq("g_bad_sv", 32'(sv_count - sv0), 32'(0));
      check_eq("ovr_g_bad", 32'(overrun), 32'(exp_ovr));
      return;
    end
    check_eq("g_ok_fe", 32'(frame_error), 32'(0));
    check_words("gyro_staged_hidden");
    xfer(1'b1, an, xtick, rstm, seen, aborted);
    if (!seen) return;
    if (aborted) begin
      for (int i = 0; i < 6; i++) exp_w[i] = 16'h0000;
      exp_ovr = 1'b0;
      check_words("rst_mid");
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_valid", 32'(sample_valid), 32'(0));
      check_eq("rst_ovr", 32'(overrun), 32'(0));
      check_eq("rst_fe", 32'(frame_error), 32'(0));
      check_eq("rst_sel", 32'(spi_if.sensor_select), 32'(0));
      check_eq("rst_ws", 32'(spi_if.write_start), 32'(0));
      step();
      check_eq("rst_no_sv", 32'(sv_count - sv0), 32'(0));
      return;
    end
    if (an != 6) begin
      check_eq("a_frame_error", 32'(frame_error), 32'(1));
      check_eq("a_bad_valid", 32'(sample_valid), 32'(0));
      check_words("a_bad_hold");
    end else begin
      exp_w[0] = le16(g_bytes[0], g_bytes[1]);
      exp_w[1] = le16(g_bytes[2], g_bytes[3]);
      exp_w[2] = le16(g_bytes[4], g_bytes[5]);
      exp_w[3] = le16(a_bytes[0], a_bytes[1]);
      exp_w[4] = le16(a_bytes[2], a_bytes[3]);
      exp_w[5] = le16(a_bytes[4], a_bytes[5]);
      check_eq("valid_pulse", 32'(sample_valid), 32'(1));
      check_eq("a_ok_fe", 32'(frame_error), 32'(0));
      check_words("publish");
    end
    step();
    check_eq("valid_one_cycle", 32'(sample_valid), 32'(0));
    check_eq("idle_after", 32'(busy), 32'(0));
    check_eq("ws_per_sample", 32'(ws_count - ws0), 32'(2));
    check_eq("sv_per_sample", 32'(sv_count - sv0), 32'((an == 6) ? 1 : 0));
    check_eq("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 8; i++) begin
      g_bytes[i] = 8'($urandom);
      a_bytes[i] = 8'($urandom);
    end
  endtask

  function automatic int rand_len();
    int r;
    r = int'($urandom_range(0, 9));
    return (r < 7) ? 6 : ((r == 7) ? 5 : 7);
  endfunction

  initial begin
    reset = 1'b1;
    sample_tick = 1'b0;
    spi_if.write_ready = 1'b1;
    spi_if.read_ready  = 1'b0;
    spi_if.read_data   = 8'h00;
    for (int i = 0; i < 6; i++) exp_w[i] = 16'h0000;
    exp_ovr = 1'b0;
    repeat (2) step();
    check_words("reset");
    check_eq("reset_busy", 32'(busy), 32'(0));
    check_eq("reset_valid", 32'(sample_valid), 32'(0));
    check_eq("reset_ovr", 32'(overrun), 32'(0));
    check_eq("reset_fe", 32'(frame_error), 32'(0));
    check_eq("reset_sel", 32'(spi_if.sensor_select), 32'(0));
    check_eq("reset_ws", 32'(spi_if.write_start), 32'(0));

    // reset wins over a simultaneous tick
    sample_tick = 1'b1;
    step();
    reset = 1'b0;
    sample_tick = 1'b0;
    check_eq("tick_under_reset", 32'(busy), 32'(0));
    step();
    check_eq("tick_under_reset_idle", 32'(busy), 32'(0));

    g_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    a_bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h00, 8'h00};
    do_sample(6, 6, 1'b0, 0, 1'b0);
    check_eq("dir_gx", 32'($unsigned(gyro_x)), 32'h0201);
    check_eq("dir_gz", 32'($unsigned(gyro_z)), 32'h0605);
    check_eq("dir_ay", 32'($unsigned(accl_y)), 32'h4030);

    rand_bytes();
    g_bytes[0:5] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h01, 8'h00};
    do_sample(6, 6, 1'b0, 0, 1'b0);
    check_eq("max_pos", 32'($unsigned(gyro_x)), 32'h7FFF);
    check_eq("max_neg", 32'($unsigned(gyro_y)), 32'h8000);
    check_eq("plus_one", 32'($unsigned(gyro_z)), 32'h0001);

    rand_bytes();
    do_sample(5, 6, 1'b0, 0, 1'b0);
    rand_bytes();
    do_sample(7, 6, 1'b0, 0, 1'b0);
    rand_bytes();
    do_sample(6, 6, 1'b0, 10, 1'b0);
    rand_bytes();
    do_sample(6, 6, 1'b1, 0, 1'b0);
    rand_bytes();
    do_sample(6, 7, 1'b0, 0, 1'b0);

    for (int n = 0; n < 15; n++) begin
      rand_bytes();
      do_sample(rand_len(), rand_len(), ($urandom_range(0, 4) == 0), 0, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end

    rand_bytes();
    do_sample(6, 6, 1'b0, 0, 1'b1);
    rand_bytes();
    do_sample(6, 6, 1'b0, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      rand_bytes();
      do_sample(rand_len(), rand_len(), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), 1'b0);
    end

    step();
    check_eq("handshake_rules", 32'(proto_err), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
